// File: rtl/chebyshev_pkg.sv
// -----------------------------------------------------------------------------
// chebyshev_pkg
// Shared helpers for the Chebyshev series evaluator:
//   clog2      - ceiling log2 for sizing counters and accumulator headroom
//   t_width    - width of the T_k registers (WL+2 so |T| up to 2 fits)
//   acc_width  - accumulator width (WL+CL+2+clog2(ORDER), cannot overflow)
//   one_val    - the Q1.(WL-1) constant ONE = 2^(WL-1), i.e. T_0
//   limit      - final output limiter
// Build option: CHEBYSHEV_SAT_EN
//   defined   -> limit() saturates to [-2^(wl-1), 2^(wl-1)-1]
//   undefined -> limit() keeps the wl LSBs (two's-complement wrap); no
//                comparators exist in that build.
// limit() and one_val() work on 64-bit values; the caller slices the width it
// needs, so accumulators wider than 64 bits are not supported.
// -----------------------------------------------------------------------------
package chebyshev_pkg;

    localparam int DEF_WL    = 16;
    localparam int DEF_CL    = 16;
    localparam int DEF_ORDER = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int t_width(input int wl);
        return wl + 2;
    endfunction

    function automatic int acc_width(input int wl, input int cl, input int order);
        return wl + cl + 2 + clog2(order);
    endfunction

    localparam int DEF_TW = t_width(DEF_WL);
    localparam int DEF_AW = acc_width(DEF_WL, DEF_CL, DEF_ORDER);

    function automatic logic signed [63:0] one_val(input int wl);
        return 64'sd1 <<< (wl - 1);
    endfunction

    function automatic logic signed [63:0] limit(input logic signed [63:0] v, input int wl);
`ifdef CHEBYSHEV_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wl - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        // Only the wl LSBs survive; the caller truncates the rest.
        return v & ((64'sd1 <<< wl) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/chebyshev_recurrence_step.sv
// -----------------------------------------------------------------------------
// chebyshev_recurrence_step
// Combinational Chebyshev recurrence step:
//   t_k = ((2 * x * t_prev1) >>> (WL-1)) - t_prev2
// The shift is arithmetic, so the rescale rounds toward minus infinity.
// Ports:
//   x        in  WL  signed sample, Q1.(WL-1)
//   t_prev1  in  TW  signed T_{k-1}
//   t_prev2  in  TW  signed T_{k-2}
//   t_k      out TW  signed T_k
// -----------------------------------------------------------------------------
module chebyshev_recurrence_step #(
    parameter int WL = 16,
    parameter int TW = WL + 2
) (
    input  logic signed [WL-1:0] x,
    input  logic signed [TW-1:0] t_prev1,
    input  logic signed [TW-1:0] t_prev2,
    output logic signed [TW-1:0] t_k
);

    // Product width leaves room for the doubling before the rescale.
    localparam int PW = WL + TW + 1;

    assign t_k = TW'((((PW'(x) * PW'(t_prev1)) <<< 1) >>> (WL - 1))) - t_prev2;

endmodule

// File: rtl/chebyshev_computation.sv
// -----------------------------------------------------------------------------
// chebyshev_computation
// Evaluates y = sum_{k=0}^{ORDER-1} c_k * T_k(x) on one sample per frame of
// ORDER cycles. The engine is self-timed and has no handshake: the frame
// counter k free-runs 0..ORDER-1, data_in is taken at k=0, one coefficient is
// taken every cycle, and data_out updates on the k=ORDER-1 edge and then holds
// for a whole frame.
// Ports:
//   clock     in   1   rising-edge clock
//   reset     in   1   synchronous, active-high; aborts any frame in flight
//   data_in   in   WL  signed sample x, Q1.(WL-1), sampled at k=0
//   coeff_in  in   CL  signed c_k, Q1.(CL-1), one per cycle in frame order
//   data_out  out  WL  signed series result, Q1.(WL-1)
// Build option: CHEBYSHEV_SAT_EN selects output saturation instead of wrap
// (see chebyshev_pkg::limit).
// -----------------------------------------------------------------------------
module chebyshev_computation
    import chebyshev_pkg::*;
#(
    parameter int WL    = 16,
    parameter int CL    = 16,
    parameter int ORDER = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic signed [WL-1:0] data_in,
    input  logic signed [CL-1:0] coeff_in,
    output logic signed [WL-1:0] data_out
);

    localparam int TW = t_width(WL);
    localparam int AW = acc_width(WL, CL, ORDER);
    localparam int KW = clog2(ORDER);
    localparam int MW = CL + TW;

    localparam logic [KW-1:0]        K_LAST = KW'(ORDER - 1);
    localparam logic signed [TW-1:0] T_ONE  = TW'(one_val(WL));

    logic [KW-1:0]        k;
    logic signed [WL-1:0] x_reg;
    logic signed [TW-1:0] t_prev1;
    logic signed [TW-1:0] t_prev2;
    logic signed [TW-1:0] t_step;
    logic signed [TW-1:0] t_k;
    logic signed [MW-1:0] term;
    logic signed [AW-1:0] term_ext;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] acc_scaled;

    chebyshev_recurrence_step #(
        .WL(WL),
        .TW(TW)
    ) u_step (
        .x      (x_reg),
        .t_prev1(t_prev1),
        .t_prev2(t_prev2),
        .t_k    (t_step)
    );

    // T_0 and T_1 are seeds; the recurrence only takes over from k=2.
    // At k=1, x_reg already holds the sample captured on the k=0 edge.
    always_comb begin
        t_k = t_step;
        if (k == '0)
            t_k = T_ONE;
        else if (k == KW'(1))
            t_k = TW'(x_reg);
    end

    assign term       = MW'(coeff_in) * MW'(t_k);
    assign term_ext   = AW'(term);
    // k=0 starts a fresh sum, so no separate accumulator clear is needed.
    assign acc_base   = (k == '0) ? '0 : acc;
    assign acc_next   = acc_base + term_ext;
    // Drop the coefficient's fractional bits to land back in Q1.(WL-1).
    assign acc_scaled = acc_next >>> (CL - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            k        <= '0;
            x_reg    <= '0;
            t_prev1  <= '0;
            t_prev2  <= '0;
            acc      <= '0;
            data_out <= '0;
        end else begin
            k <= (k == K_LAST) ? '0 : k + KW'(1);
            if (k == '0)
                x_reg <= data_in;
            t_prev2 <= t_prev1;
            t_prev1 <= t_k;
            acc     <= acc_next;
            if (k == K_LAST)
                data_out <= WL'(limit(64'(acc_scaled), WL));
        end
    end

endmodule

// File: tb/tb_chebyshev_computation.sv
// -----------------------------------------------------------------------------
// tb_chebyshev_computation
// Drives directed and random frames into chebyshev_computation. The driver
// pushes each frame's expected result into exp_q as the last coefficient is
// presented; a monitor pops it on the frame-closing edge and checks data_out
// on every cycle (reset value, update timing and hold).
// -----------------------------------------------------------------------------
module tb_chebyshev_computation;

    localparam int WL    = 16;
    localparam int CL    = 16;
    localparam int ORDER = 4;

    typedef logic signed [CL-1:0] coeff_arr_t [ORDER];

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic signed [WL-1:0] data_in = '0;
    logic signed [CL-1:0] coeff_in = '0;
    logic signed [WL-1:0] data_out;

    logic [WL-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    bit            end_pending = 1'b0;

    chebyshev_computation #(
        .WL   (WL),
        .CL   (CL),
        .ORDER(ORDER)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .coeff_in(coeff_in),
        .data_out(data_out)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Direct evaluation of the series with 64-bit integers.
    function automatic logic [WL-1:0] model(input logic signed [WL-1:0] x, input coeff_arr_t c);
        longint t[ORDER];
        longint xl;
        longint sum;
        longint y;
        xl  = longint'(x);
        sum = 0;
        for (int i = 0; i < ORDER; i++) begin
            if (i == 0)
                t[i] = longint'(1) <<< (WL - 1);
            else if (i == 1)
                t[i] = xl;
            else
                t[i] = ((2 * xl * t[i-1]) >>> (WL - 1)) - t[i-2];
            sum = sum + longint'(c[i]) * t[i];
        end
        y = sum >>> (CL - 1);
`ifdef CHEBYSHEV_SAT_EN
        if (y > (longint'(1) <<< (WL - 1)) - 1)
            y = (longint'(1) <<< (WL - 1)) - 1;
        else if (y < -(longint'(1) <<< (WL - 1)))
            y = -(longint'(1) <<< (WL - 1));
`endif
        return y[WL-1:0];
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @%0t: got %0d (0x%h) expected %0d (0x%h)",
                     name, $time, $signed(act), act, $signed(exp_v), exp_v);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Each task is entered just after a falling edge and returns just after a
    // falling edge, so every loop iteration spans exactly one rising edge.
    task automatic drive_frame(input logic signed [WL-1:0] x, input coeff_arr_t c,
                               input bit use_exp, input logic [WL-1:0] exp_v);
        for (int i = 0; i < ORDER; i++) begin
            // Off-slot data_in is noise the DUT must ignore.
            data_in  = (i == 0) ? x : WL'($urandom);
            coeff_in = c[i];
            if (i == ORDER - 1) begin
                exp_q.push_back(use_exp ? exp_v : model(x, c));
                end_pending = 1'b1;
            end
            @(negedge clock);
        end
    endtask

    // Starts a frame and hits reset on its k=2 edge.
    task automatic abort_frame(input logic signed [WL-1:0] x, input coeff_arr_t c);
        for (int i = 0; i < 3; i++) begin
            data_in  = (i == 0) ? x : WL'($urandom);
            coeff_in = c[i];
            reset    = (i == 2);
            @(negedge clock);
        end
        reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [WL-1:0] held;
        bit            pop;
        bit            in_rst;
        held = '0;
        forever begin
            @(posedge clock);
            pop         = end_pending;
            end_pending = 1'b0;
            in_rst      = reset;
            #1;
            if (in_rst) begin
                held = '0;
            end else if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty @%0t: got no expected value, required one", $time);
                end else begin
                    held = exp_q.pop_front();
                end
            end
            check(pop ? "data_out_update" : "data_out_hold", data_out, held);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        coeff_arr_t c;
        logic signed [WL-1:0] x;

        // Reset for three rising edges, released at a falling edge so the
        // next rising edge is frame cycle k=0.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // T_0 only: 0.5 * ONE
        c = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0};
        drive_frame(16'sd0, c, 1'b1, 16'd16384);

        // x=0.5: T = {1, 0.5, -0.5, -1}
        c = '{16'sd0, 16'sd16384, 16'sd16384, 16'sd16384};
        drive_frame(16'sd16384, c, 1'b1, 16'hC000);

        // Pre-limit sum 65535: saturates or wraps
        c = '{16'sd32767, 16'sd0, 16'sh8000, 16'sd0};
`ifdef CHEBYSHEV_SAT_EN
        drive_frame(16'sd0, c, 1'b1, 16'd32767);
`else
        drive_frame(16'sd0, c, 1'b1, 16'hFFFF);
`endif

        // Back-to-back frames, floor on the final shift
        c = '{16'sd0, 16'sd32767, 16'sd0, 16'sd0};
        drive_frame(16'sd16384, c, 1'b1, 16'd16383);
        drive_frame(16'sd0, c, 1'b1, 16'd0);

        // Nonzero result, then a frame aborted by reset at k=2, then a
        // clean frame that must not see stale accumulator content.
        c = '{16'sd0, 16'sd16384, 16'sd16384, 16'sd16384};
        drive_frame(16'sd16384, c, 1'b1, 16'hC000);
        c = '{16'sd12000, 16'sd20000, 16'sd30000, 16'sd1000};
        abort_frame(-16'sd9000, c);
        c = '{16'sd0, 16'sd16384, 16'sd16384, 16'sd16384};
        drive_frame(16'sd16384, c, 1'b1, 16'hC000);

        // Extreme samples against the model
        c = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
        drive_frame(16'sh8000, c, 1'b0, '0);
        c = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        drive_frame(16'sd32767, c, 1'b0, '0);
        drive_frame(16'sh8000, c, 1'b0, '0);

        // Random frames
        for (int f = 0; f < 60; f++) begin
            x = WL'($urandom);
            for (int i = 0; i < ORDER; i++)
                c[i] = CL'($urandom_range(0, 65535));
            drive_frame(x, c, 1'b0, '0);
        end

        // Let the last result hold for a couple of cycles, then drain check.
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
